// File: rtl/msrv32_instr_fetch.sv
// msrv32_instr_fetch: MSRV32 instruction fetch stage.
// Owns the PC and issues one outstanding word request at a time over a
// req/gnt/rvalid handshake. Returned words are buffered with their PCs in a
// DEPTH-entry FIFO that feeds the instruction mux. A flush redirects the PC,
// clears the FIFO, and discards any response still in flight.
// Optional feature macro: MSRV32_FETCH_ALIGN_CHECK_EN (misaligned redirect pulse).
module msrv32_instr_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        misaligned_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    ret_pc_q, ret_pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [31:0]    fifo_pc_q  [DEPTH];
  logic [31:0]    fifo_ins_q [DEPTH];

  logic handshake;
  logic push;
  logic pop;
  logic outstanding;

  // Wrap a FIFO pointer at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_req_out    = (state_q == FETCH) && (cnt_q < CW'(DEPTH)) && !ms_riscv32_mp_rst_in;
  assign imem_addr_out   = pc_q;
  assign instr_valid_out = (cnt_q != '0);
  assign instr_out       = instr_valid_out ? fifo_ins_q[rd_q] : NOP;
  assign pc_out          = instr_valid_out ? fifo_pc_q[rd_q]  : '0;

  assign handshake   = imem_req_out && imem_gnt_in;
  // A request remains outstanding past this cycle unless its response arrives now.
  assign outstanding = ((state_q == WAIT) && !imem_rvalid_in) || handshake ||
                       ((state_q == DISCARD) && !imem_rvalid_in);

  // Next-state logic: FSM, PC, FIFO bookkeeping; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_pc_d = ret_pc_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    push     = 1'b0;
    pop      = instr_valid_out && !stall_in;

    case (state_q)
      FETCH: begin
        if (handshake) begin
          pc_d     = pc_q + 32'd4;
          ret_pc_d = pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_in) begin
          push    = 1'b1;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (imem_rvalid_in) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (flush_in) begin
      push    = 1'b0;
      pop     = 1'b0;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = {redirect_pc_in[31:2], 2'b00};
      state_d = outstanding ? DISCARD : FETCH;
    end else begin
      if (push) wr_d = ptr_next(wr_q);
      if (pop)  rd_d = ptr_next(rd_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q  <= FETCH;
      pc_q     <= BOOT_ADDR;
      ret_pc_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ret_pc_q <= ret_pc_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push && !flush_in && !ms_riscv32_mp_rst_in) begin
      fifo_pc_q[wr_q]  <= ret_pc_q;
      fifo_ins_q[wr_q] <= imem_rdata_in;
    end
  end

`ifdef MSRV32_FETCH_ALIGN_CHECK_EN
  logic mis_q;

  // One-cycle pulse after a flush to a non-word-aligned target.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) mis_q <= 1'b0;
    else                      mis_q <= flush_in && (redirect_pc_in[1:0] != 2'b00);
  end

  assign misaligned_out = mis_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_in[1:0];
  assign misaligned_out      = 1'b0;
`endif

endmodule
